key_scheduler: RTL

//  Sequences the piano's raw key inputs into one monophonic note request.

---
 rtl/piano_pkg.sv | 30 +++
 rtl/key_scheduler_if.sv | 17 +
 rtl/key_debouncer.sv | 45 ++++
 rtl/key_scheduler.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared key/octave types, FSM states and priority helpers for the piano key scheduler.
// Pure declarations; no timing or flow control of its own.
package piano_pkg;
  localparam int NUM_KEYS = 7;
  localparam int NUM_OCT  = 4;

  typedef logic [2:0] key_t;
  typedef logic [1:0] oct_t;
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  // Lowest set key index wins; returns 0 for an empty vector.
  function automatic key_t lowest_key(input logic [NUM_KEYS-1:0] v);
    key_t k;
    k = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) k = key_t'(i);
    end
    return k;
  endfunction

  // Button i selects octave NUM_OCT-1-i; the highest rising i wins.
  function automatic oct_t top_octave(input logic [NUM_OCT-1:0] rise);
    oct_t o;
    o = '0;
    for (int i = 0; i < NUM_OCT; i++) begin
      if (rise[i]) o = oct_t'(NUM_OCT - 1 - i);
    end
    return o;
  endfunction
endpackage

// File: rtl/key_scheduler_if.sv
// Raw keyboard inputs and the monophonic note request towards the tone generator.
// Plain level signals; no handshake or backpressure.
interface key_scheduler_if;
  import piano_pkg::*;

  logic [NUM_KEYS-1:0] sw_bus;
  logic [NUM_OCT-1:0]  note_bus;
  key_t                note_idx;
  oct_t                octave;
  logic                note_valid;
  logic                note_change;

  modport master (output sw_bus, note_bus,
                  input  note_idx, octave, note_valid, note_change);
  modport slave  (input  sw_bus, note_bus,
                  output note_idx, octave, note_valid, note_change);
endinterface

// File: rtl/key_debouncer.sv
// One-bit 2-flop synchroniser plus debounce counter; level flips after DEB_CYCLES stable cycles.
// Latency 2 + DEB_CYCLES cycles from a stable raw edge to level/rise/fall; no backpressure.
module key_debouncer #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // rise/fall are registered so they coincide with the cycle level changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= sync2;
        rise  <= sync2;
        fall  <= ~sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/key_scheduler.sv
// Debounces keys/octave buttons and arbitrates them into one note with last-note priority and a re-trigger gap.
// Press-to-note latency 2 + DEB_CYCLES + 1 cycles; outputs are free-running levels with no backpressure.
module key_scheduler
  import piano_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int GAP_CYCLES = 2500
) (
  input logic            clk,
  input logic            rst,
  key_scheduler_if.slave bus
);
  localparam int NUM_IN = NUM_KEYS + NUM_OCT;
  localparam int GW     = $clog2(GAP_CYCLES + 1);

  logic [NUM_IN-1:0]   raw_in;
  logic [NUM_IN-1:0]   deb_level;
  logic [NUM_IN-1:0]   deb_rise;
  logic [NUM_IN-1:0]   deb_fall;
  logic [NUM_KEYS-1:0] key_held;
  logic [NUM_KEYS-1:0] key_new;
  logic [NUM_OCT-1:0]  oct_new;
  logic                unused_deb;

  assign raw_in = {bus.sw_bus, bus.note_bus};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_deb
    key_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw_in[i]),
      .level (deb_level[i]),
      .rise  (deb_rise[i]),
      .fall  (deb_fall[i])
    );
  end

  // Key k lives on sw_bus[6-k], which sits above the octave bits in raw_in.
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_map
    assign key_held[k] = deb_level[NUM_IN - 1 - k];
    assign key_new[k]  = deb_rise[NUM_IN - 1 - k];
  end
  assign oct_new    = deb_rise[NUM_OCT-1:0];
  assign unused_deb = |{deb_fall, deb_level[NUM_OCT-1:0]};

  logic    any_new;
  logic    any_held;
  key_t    new_key;
  key_t    held_key;

  assign any_new  = |key_new;
  assign any_held = |key_held;
  assign new_key  = lowest_key(key_new);
  assign held_key = lowest_key(key_held);

  state_t        state;
  state_t        state_nxt;
  key_t          pend;
  key_t          pend_nxt;
  key_t          idx_nxt;
  oct_t          oct_nxt;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_nxt;
  logic          valid_nxt;
  logic          change_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      pend            <= '0;
      gap_cnt         <= '0;
      bus.note_idx    <= '0;
      bus.octave      <= '0;
      bus.note_valid  <= 1'b0;
      bus.note_change <= 1'b0;
    end else begin
      state           <= state_nxt;
      pend            <= pend_nxt;
      gap_cnt         <= gap_nxt;
      bus.note_idx    <= idx_nxt;
      bus.octave      <= oct_nxt;
      bus.note_valid  <= valid_nxt;
      bus.note_change <= change_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    gap_nxt   = gap_cnt;
    idx_nxt   = bus.note_idx;
    oct_nxt   = (|oct_new) ? top_octave(oct_new) : bus.octave;
    case (state)
      IDLE: begin
        if (any_new) begin
          state_nxt = PLAY;
          idx_nxt   = new_key;
        end
      end
      PLAY: begin
        if (any_new) begin
          state_nxt = GAP;
          pend_nxt  = new_key;
          gap_nxt   = '0;
        end else if (!key_held[bus.note_idx]) begin
          if (any_held) begin
            state_nxt = GAP;
            pend_nxt  = held_key;
            gap_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      GAP: begin
        // A fresh press during the gap retargets it and restarts the silence.
        if (any_new) begin
          pend_nxt = new_key;
          gap_nxt  = '0;
        end else if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          if (key_held[pend]) begin
            state_nxt = PLAY;
            idx_nxt   = pend;
          end else if (any_held) begin
            state_nxt = PLAY;
            idx_nxt   = held_key;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    valid_nxt  = (state_nxt == PLAY);
    change_nxt = valid_nxt && (!bus.note_valid || (idx_nxt != bus.note_idx) ||
                               (oct_nxt != bus.octave));
  end
endmodule
